// File: rtl/mem_stage.sv
// MEM stage: req/ack handshake to a variable-latency data memory,
// stalling the front end and bubbling MEM_WB while an access is in flight.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [1:0]  WB_i,
  input  logic [31:0] ALU_i,
  input  logic [31:0] WriteData_i,
  input  logic [4:0]  RegDst_i,
  output logic [1:0]  WB_o,
  output logic [31:0] ReadData_o,
  output logic [31:0] ALU_o,
  output logic [4:0]  RegDst_o,
  output logic        stall_o,
  output logic        err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic [31:0] rdata_q;
  logic        err_q;

  logic need;
  logic mis;
  logic bubble;

  assign need     = MemRead_i | MemWrite_i;
  assign mis      = ALU_i[1:0] != 2'b00;
  assign bubble   = {WB_i[1], 1'b0} != WB_i;
  assign ALU_o    = ALU_i;
  assign RegDst_o = RegDst_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= S_IDLE;
      cnt     <= 8'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (need && !mis) begin
            state <= S_WAIT;
            cnt   <= 8'd0;
          end
        end
        S_WAIT: begin
          if (mem_ack_i) begin
            rdata_q <= MemWrite_i ? 32'd0 : mem_rdata_i;
            err_q   <= 1'b0;
            state   <= S_DONE;
          end else if (cnt == LAST) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b1;
            state   <= S_DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    WB_o        = WB_i;
    ReadData_o  = 32'd0;
    stall_o     = 1'b0;
    err_o       = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = 32'd0;
    mem_wdata_o = 32'd0;
    unique case (state)
      S_IDLE: begin
        if (need) begin
          WB_o    = {WB_i[1], 1'b0};
          err_o   = mis;
          stall_o = !mis;
        end
      end
      S_WAIT: begin
        WB_o        = {WB_i[1], 1'b0};
        stall_o     = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = MemWrite_i;
        mem_addr_o  = {ALU_i[31:2], 2'b00};
        mem_wdata_o = WriteData_i;
      end
      S_DONE: begin
        ReadData_o = rdata_q;
        err_o      = err_q;
        if (err_q && bubble) WB_o = {WB_i[1], 1'b0};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with TIMEOUT = 4.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  wb_in;
  logic [31:0] alu_in;
  logic [31:0] wdata_in;
  logic [4:0]  rd_in;
  logic [1:0]  wb_out;
  logic [31:0] rdata_out;
  logic [31:0] alu_out;
  logic [4:0]  rd_out;
  logic        stall;
  logic        err;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] mrdata;

  int vectors = 0;
  int miscompares = 0;
  int sc;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .MemRead_i(mem_read),
    .MemWrite_i(mem_write),
    .WB_i(wb_in),
    .ALU_i(alu_in),
    .WriteData_i(wdata_in),
    .RegDst_i(rd_in),
    .WB_o(wb_out),
    .ReadData_o(rdata_out),
    .ALU_o(alu_out),
    .RegDst_o(rd_out),
    .stall_o(stall),
    .err_o(err),
    .mem_req_o(req),
    .mem_we_o(we),
    .mem_addr_o(addr),
    .mem_wdata_o(wdata),
    .mem_ack_i(ack),
    .mem_rdata_i(mrdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic rd, input logic wr, input logic [1:0] wb,
                    input logic [31:0] a, input logic [31:0] d,
                    input logic [4:0] r);
    mem_read  = rd;
    mem_write = wr;
    wb_in     = wb;
    alu_in    = a;
    wdata_in  = d;
    rd_in     = r;
  endtask

  initial begin
    rst_n = 1'b0;
    ack = 1'b0;
    mrdata = 32'd0;
    op(1'b1, 1'b0, 2'b11, 32'h100, 32'd0, 5'd1);
    #2;
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_rdata", rdata_out, 32'd0);
    chk("rst_stall_decode", 32'(stall), 32'd1);
    cyc();
    op(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
    cyc();
    rst_n = 1'b1;

    // ADD pass-through
    cyc();
    op(1'b0, 1'b0, 2'b01, 32'h1234, 32'd0, 5'd5);
    #3;
    chk("add_wb", 32'(wb_out), 32'h1);
    chk("add_alu", alu_out, 32'h1234);
    chk("add_rd", 32'(rd_out), 32'd5);
    chk("add_stall", 32'(stall), 32'd0);
    chk("add_err", 32'(err), 32'd0);

    // LW 0x100, ack on 3rd WAIT cycle
    sc = 0;
    cyc();
    op(1'b1, 1'b0, 2'b11, 32'h100, 32'd0, 5'd3);
    #3;
    sc += int'(stall);
    chk("lw_idle_req", 32'(req), 32'd0);
    chk("lw_idle_wb", 32'(wb_out), 32'h2);
    cyc();
    #3;
    sc += int'(stall);
    chk("lw_w1_req", 32'(req), 32'd1);
    chk("lw_w1_addr", addr, 32'h100);
    chk("lw_w1_we", 32'(we), 32'd0);
    chk("lw_w1_wb", 32'(wb_out), 32'h2);
    cyc();
    #3;
    sc += int'(stall);
    cyc();
    ack = 1'b1;
    mrdata = 32'hDEADBEEF;
    #3;
    sc += int'(stall);
    chk("lw_w3_req", 32'(req), 32'd1);
    cyc();
    ack = 1'b0;
    mrdata = 32'd0;
    #3;
    sc += int'(stall);
    chk("lw_stall_cycles", 32'(sc), 32'd4);
    chk("lw_done_rdata", rdata_out, 32'hDEADBEEF);
    chk("lw_done_wb", 32'(wb_out), 32'h3);
    chk("lw_done_req", 32'(req), 32'd0);
    chk("lw_done_err", 32'(err), 32'd0);

    // SW 0x8 with immediate ack, then back-to-back LW
    sc = 0;
    cyc();
    op(1'b0, 1'b1, 2'b00, 32'h8, 32'hCAFE0001, 5'd0);
    #3;
    sc += int'(stall);
    chk("sw_idle_req", 32'(req), 32'd0);
    cyc();
    ack = 1'b1;
    mrdata = 32'h5555AAAA;
    #3;
    sc += int'(stall);
    chk("sw_we", 32'(we), 32'd1);
    chk("sw_wdata", wdata, 32'hCAFE0001);
    chk("sw_addr", addr, 32'h8);
    cyc();
    ack = 1'b0;
    #3;
    sc += int'(stall);
    chk("sw_stall_cycles", 32'(sc), 32'd2);
    chk("sw_done_rdata", rdata_out, 32'd0);
    chk("sw_done_wdata_idle", wdata, 32'd0);
    cyc();
    op(1'b1, 1'b0, 2'b11, 32'h20, 32'hFFFFFFFF, 5'd7);
    #3;
    chk("b2b_idle_stall", 32'(stall), 32'd1);
    chk("b2b_idle_req", 32'(req), 32'd0);
    cyc();
    ack = 1'b1;
    mrdata = 32'h12345678;
    #3;
    chk("b2b_req", 32'(req), 32'd1);
    chk("b2b_addr", addr, 32'h20);
    chk("b2b_wdata", wdata, 32'hFFFFFFFF);
    cyc();
    ack = 1'b0;
    #3;
    chk("b2b_rdata", rdata_out, 32'h12345678);
    chk("b2b_wb", 32'(wb_out), 32'h3);

    // LW timeout
    sc = 0;
    cyc();
    op(1'b1, 1'b0, 2'b11, 32'h40, 32'd0, 5'd9);
    #3;
    chk("to_idle_stall", 32'(stall), 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      #3;
      sc += int'(req);
    end
    chk("to_req_cycles", 32'(sc), 32'd4);
    cyc();
    #3;
    chk("to_req_drop", 32'(req), 32'd0);
    chk("to_err", 32'(err), 32'd1);
    chk("to_rdata", rdata_out, 32'd0);
    chk("to_wb", 32'(wb_out), 32'h2);
    chk("to_stall", 32'(stall), 32'd0);
    cyc();
    op(1'b0, 1'b0, 2'b01, 32'h44, 32'd0, 5'd2);
    ack = 1'b1;
    mrdata = 32'hFFFF0000;
    #3;
    chk("late_req", 32'(req), 32'd0);
    chk("late_err", 32'(err), 32'd0);
    chk("late_wb", 32'(wb_out), 32'h1);
    cyc();
    ack = 1'b0;
    #3;
    chk("late_stall", 32'(stall), 32'd0);
    chk("late_rdata", rdata_out, 32'd0);

    // misaligned LW 0x102
    cyc();
    op(1'b1, 1'b0, 2'b11, 32'h102, 32'd0, 5'd4);
    #3;
    chk("mis_err", 32'(err), 32'd1);
    chk("mis_stall", 32'(stall), 32'd0);
    chk("mis_req", 32'(req), 32'd0);
    chk("mis_wb", 32'(wb_out), 32'h2);
    cyc();
    op(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
    #3;
    chk("mis_after_err", 32'(err), 32'd0);
    chk("mis_after_req", 32'(req), 32'd0);

    // reset mid-WAIT
    cyc();
    op(1'b1, 1'b0, 2'b11, 32'h200, 32'd0, 5'd6);
    cyc();
    #1;
    chk("rw_req_before", 32'(req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rw_req_after", 32'(req), 32'd0);
    op(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
    #1;
    chk("rw_stall", 32'(stall), 32'd0);
    cyc();
    rst_n = 1'b1;
    ack = 1'b1;
    mrdata = 32'h0BADF00D;
    #3;
    chk("rw_late_req", 32'(req), 32'd0);
    cyc();
    ack = 1'b0;
    #3;
    chk("rw_late_rdata", rdata_out, 32'd0);
    chk("rw_late_stall", 32'(stall), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
